// File: rtl/sim_sram_pkg.sv
// Shared types and helpers for the simulation SRAM burst read sequencer.
// Holds the FSM state type, default geometry and the wrap-address helper.
package sim_sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_AW         = 32;
  localparam int DEF_DW         = 32;
  localparam int DEF_LEN_W      = 8;
  localparam int DEF_RD_LAT     = 1;
  localparam int DEF_FIFO_DEPTH = 4;

  // The response buffer must hold every in-flight read plus the beat being presented.
  localparam bit DEF_CFG_OK = (DEF_FIFO_DEPTH >= DEF_RD_LAT + 1);

  function automatic bit cfg_ok(input int depth, input int rd_lat);
    return (rd_lat >= 1) && (depth >= rd_lat + 1) && ((depth & (depth - 1)) == 0);
  endfunction

  // Wrapping burst: the bits under mask count up and roll over, the rest stay fixed.
  function automatic logic [63:0] wrap_addr(input logic [63:0] addr, input logic [63:0] mask);
    return (addr & ~mask) | ((addr + 64'd1) & mask);
  endfunction

endpackage

// File: rtl/sim_sram_rsp_fifo.sv
// Response buffer for the burst sequencer: power-of-two synchronous FIFO
// with an occupancy count that the issue side uses as its credit source.
module sim_sram_rsp_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [W-1:0]             i_push_data,
  input  logic                     i_pop,
  output logic                     o_valid,
  output logic [W-1:0]             o_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_wr;
  logic          w_rd;

  assign w_full = (r_count == CW'(DEPTH));
  assign w_rd   = i_pop && (r_count != '0);
  // A pop in the same cycle frees the slot being written.
  assign w_wr   = i_push && (!w_full || w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end

  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/sim_sram_burst_seq.sv
// Burst read sequencer: turns one command into sequential (incrementing or
// wrapping) SRAM word reads and returns the data on a valid/ready channel.
module sim_sram_burst_seq
  import sim_sram_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_wrap,
  output logic             sram_req,
  output logic [AW-1:0]    sram_addr,
  input  logic [DW-1:0]    sram_rdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_data,
  output logic             rsp_last,
  output logic [AW-1:0]    start_addr,
  output logic             busy
);

  localparam int  OCC_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int  CW     = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
  // A misconfigured instance never issues, so the fault shows up immediately.
  localparam bit  CFG_OK = cfg_ok(FIFO_DEPTH, RD_LAT);

  state_t           r_state;
  logic [AW-1:0]    r_addr;
  logic [AW-1:0]    r_start;
  logic [LEN_W-1:0] r_remain;
  logic [LEN_W-1:0] r_mask;
  logic             r_wrap;
  logic             r_vld [RD_LAT];
  logic             r_lst [RD_LAT];

  logic             w_cmd_fire;
  logic             w_issue;
  logic             w_pop;
  logic             w_push;
  logic [CW-1:0]    w_inflight;
  logic [CW-1:0]    w_committed;
  logic [OCC_W-1:0] w_occ;
  logic             w_fifo_valid;
  logic [DW:0]      w_fifo_data;
  logic [AW-1:0]    w_next_addr;

  assign cmd_ready  = (r_state == IDLE) && !rst;
  assign w_cmd_fire = cmd_valid && cmd_ready;
  assign w_pop      = w_fifo_valid && rsp_ready;
  assign w_push     = r_vld[RD_LAT-1];

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + CW'(r_vld[i]);
    end
  end

  // Every issued read already owns a FIFO slot; a pop this cycle returns one.
  assign w_committed = w_inflight + CW'(w_occ);
  assign w_issue     = CFG_OK && (r_state == BURST) &&
                       ((w_committed - CW'(w_pop)) < CW'(FIFO_DEPTH));

  assign w_next_addr = r_wrap ? AW'(wrap_addr(64'(r_addr), 64'(r_mask)))
                              : r_addr + AW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_start  <= '0;
      r_remain <= '0;
      r_mask   <= '0;
      r_wrap   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cmd_fire) begin
            r_state  <= BURST;
            r_addr   <= cmd_addr;
            r_start  <= cmd_addr;
            r_remain <= cmd_len;
            r_mask   <= cmd_len;
            r_wrap   <= cmd_wrap;
          end
        end
        BURST: begin
          if (w_issue) begin
            r_addr   <= w_next_addr;
            r_remain <= r_remain - LEN_W'(1);
            if (r_remain == '0) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_pop && w_fifo_data[0] && (w_occ == OCC_W'(1)) && (w_inflight == '0)) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read-latency shadow of the request strobe; reset drops any late SRAM data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_vld[i] <= 1'b0;
        r_lst[i] <= 1'b0;
      end
    end else begin
      r_vld[0] <= w_issue;
      r_lst[0] <= w_issue && (r_remain == '0);
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_lst[i] <= r_lst[i-1];
      end
    end
  end

  sim_sram_rsp_fifo #(
    .W     (DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data ({sram_rdata, r_lst[RD_LAT-1]}),
    .i_pop       (w_pop),
    .o_valid     (w_fifo_valid),
    .o_data      (w_fifo_data),
    .o_count     (w_occ)
  );

  assign sram_req   = w_issue;
  assign sram_addr  = r_addr;
  assign rsp_valid  = w_fifo_valid;
  assign rsp_data   = w_fifo_data[DW:1];
  assign rsp_last   = w_fifo_data[0];
  assign start_addr = r_start;
  assign busy       = (r_state != IDLE);

endmodule
